serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that sequences a single external 1-bit full adder (A, B, CI -> S, CO) to add two WIDTH-bit operands over WIDTH clock cycles. It latches operands on a start strobe, feeds the adder one bit per cycle LSB-first, keeps the carry in a flip-flop between cycles, and assembles the WIDTH-bit sum. It sits between a requester issuing add commands and the shared full-adder cell.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits (>= 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only when not busy.
- A  input  WIDTH  operand A, sampled with start.
- B  input  WIDTH  operand B, sampled with start.
- CI  input  1  initial carry-in, sampled with start.
- busy  output  1  high while the addition is in progress.
- done  output  1  one-cycle pulse when S/CO are valid.
- S  output  WIDTH  sum; held until the next accepted start.
- CO  output  1  final carry-out; held with S.
- fa_a  output  1  bit to the full adder's A.
- fa_b  output  1  bit to the full adder's B.
- fa_ci  output  1  carry to the full adder's CI.
- fa_s  input  1  full adder's S.
- fa_co  input  1  full adder's CO.
- OV  output  1  signed overflow (only with SERIAL_ADDER_OVF_EN).

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE with start=1: load a_sh<=A, b_sh<=B, carry<=CI, cnt<=0, clear S, CO (and OV); go RUN.
- RUN, each cycle: fa_a=a_sh[0], fa_b=b_sh[0], fa_ci=carry (combinational from registers). At the edge: S<={fa_s, S[WIDTH-1:1]}, a_sh/b_sh shift right, carry<=fa_co, cnt<=cnt+1.
- RUN with cnt==WIDTH-1: after the update, CO<=fa_co; go DONE.
- DONE: done=1 for exactly one cycle; then IDLE unless start is accepted in that cycle.
- fa_a/fa_b/fa_ci are 0 outside RUN.
- start while busy: ignored, with no effect on state, operands or outputs.
- Operand inputs are don't-care except in the cycle start is accepted.
- cnt width: clog2(WIDTH); it does not wrap within an operation.

## Timing
- Reset values: busy=0, done=0, S=0, CO=0, OV=0, fa_*=0, state=IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values; the in-flight result is discarded. No done pulse is generated.
- start accepted at edge 0 -> busy=1 from edge 0 through edge WIDTH (WIDTH RUN cycles).
- done=1 and busy=0 in the cycle following edge WIDTH. Latency from start to done is WIDTH+1 cycles.
- S and CO are stable from done until the edge that accepts the next start.
- Back-to-back operation: start in the DONE cycle is accepted, giving a throughput of one add per WIDTH+1 cycles.

## Configuration
- SERIAL_ADDER_OVF_EN defined: OV port present. In the final RUN cycle, OV<=carry^fa_co (carry into MSB xor carry out); it is valid and held alongside CO.
- SERIAL_ADDER_OVF_EN undefined: no OV port and no related logic. All other behaviour is identical.

## Test plan
Bench: WIDTH=8, with a behavioural 1-bit full adder on the fa_* ports.
- A=8'hFF, B=8'h01, CI=0, start -> done 9 cycles later; S=8'h00, CO=1.
- A=8'h5A, B=8'h33, CI=1 -> S=8'h8E, CO=0. S is held unchanged for 5 idle cycles after done.
- start pulsed again with A=8'h00 at cycle 3 of an add of 8'h10+8'h20 -> ignored; S=8'h30, CO=0, done exactly once.
- rst asserted at cycle 4 of an add -> busy=0, S=0, CO=0 immediately, and no done pulse. A subsequent 8'h01+8'h01 gives S=8'h02.
- start held in the DONE cycle with A=8'h80, B=8'h80, CI=0 -> second add begins with no idle gap; S=8'h00, CO=1, done 9 cycles after the first done.
- With SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> S=8'h80, CO=0, OV=1. 8'hFF+8'h01 -> OV=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one external full adder LSB-first over WIDTH cycles.
// Optional signed-overflow output OV is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OV
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;

  // A start strobe is only honoured when no addition is in flight.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_ci     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        fa_a  = a_sh[0];
        fa_b  = b_sh[0];
        fa_ci = carry;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      CO    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      OV    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= CI;
      cnt   <= '0;
      S     <= '0;
      CO    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      OV    <= 1'b0;
`endif
    end else if (state == RUN) begin
      // Sum bits enter at the MSB so the LSB lands in S[0] after WIDTH shifts.
      S     <= {fa_s, S[WIDTH-1:1]};
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        CO <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
        // carry still holds the carry into the MSB during the final cycle.
        OV <= carry ^ fa_co;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed-vector bench for serial_adder_ctrl with a behavioural full adder on fa_*.
// OV vectors are included when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CI;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         CO;
  logic         fa_a;
  logic         fa_b;
  logic         fa_ci;
  logic         fa_s;
  logic         fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic         OV;
`endif

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int d0;
  logic [W:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .CI    (CI),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .CO    (CO),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_ci (fa_ci),
    .fa_s  (fa_s),
    .fa_co (fa_co)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OV    (OV)
`endif
  );

  // clock / behavioural full adder
  always #5 clk = ~clk;
  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives start for one cycle from the current negedge; the accepting edge follows.
  task automatic issue_now(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input logic [W-1:0] exp_s, input logic exp_co);
    A     = a;
    B     = b;
    CI    = ci;
    start = 1'b1;
    exp_q.push_back({exp_co, exp_s});
    @(negedge clk);
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    CI    = 1'($urandom_range(0, 1));
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W-1:0] exp_s, input logic exp_co);
    @(negedge clk);
    issue_now(a, b, ci, exp_s, exp_co);
  endtask

  // k0 = negedges already elapsed since start was raised; latency counted in the same units.
  task automatic wait_done(input string tag, input int k0, input int lat_exp);
    int   k;
    bit   got;
    logic [W:0] e;
    k   = k0;
    got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      got = (done === 1'b1);
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 'x;
    if (got) begin
      check({tag, "_latency"}, 32'(k), 32'(lat_exp));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_sum"}, 32'({CO, S}), 32'(e));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    CI    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(S), 32'd0);
    check("rst_co", 32'(CO), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ov", 32'(OV), 32'd0);
`endif
    rst = 1'b0;

    // FF + 01: full carry ripple
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    wait_done("ff_01", 1, 9);
    @(negedge clk);
    check("ff_01_done_one_cycle", 32'(done), 32'd0);
    check("idle_fa_zero", 32'({fa_a, fa_b, fa_ci}), 32'd0);

    // 5A + 33 + 1, then hold check
    issue(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0);
    wait_done("5a_33", 1, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_s", 32'({CO, S}), 32'h08E);
    end

    // start pulsed mid-run must be ignored
    d0 = done_cnt;
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    @(negedge clk);
    A     = 8'h00;
    B     = 8'h00;
    CI    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignored_busy", 32'(busy), 32'd1);
    wait_done("ignored_start", 3, 9);
    repeat (12) @(negedge clk);
    check("ignored_done_once", 32'(done_cnt - d0), 32'd1);

    // reset mid-operation discards the result
    issue(8'h55, 8'h0F, 1'b0, 8'h64, 1'b0);
    repeat (3) @(negedge clk);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_s", 32'(S), 32'd0);
    check("midrst_co", 32'(CO), 32'd0);
    check("midrst_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);
    // The interrupted addition never completes, so its expectation is dropped.
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    wait_done("01_01", 1, 9);

    // back-to-back: next start accepted in the DONE cycle
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    wait_done("b2b_first", 1, 9);
    issue_now(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    wait_done("b2b_second", 1, 9);

`ifdef SERIAL_ADDER_OVF_EN
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    wait_done("ovf_7f", 1, 9);
    check("ovf_7f_ov", 32'(OV), 32'd1);
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    wait_done("ovf_ff", 1, 9);
    check("ovf_ff_ov", 32'(OV), 32'd0);
`endif

    @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
